// File: rtl/fetch_unit.sv
// Instruction fetch stage: on-chip instruction memory, fetch PC, IF/ID pipeline
// register and a small IDLE/RUN/HALT control FSM with sticky fetch fault.
module fetch_unit #(
  parameter int unsigned XLEN       = 32,
  parameter int unsigned IMEM_DEPTH = 64,
  parameter int unsigned RESET_PC   = 0
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          run,
  input  logic                          imem_we,
  input  logic [$clog2(IMEM_DEPTH)-1:0] imem_waddr,
  input  logic [XLEN-1:0]               imem_wdata,
  input  logic                          stall,
  input  logic                          flush,
  input  logic                          branch,
  input  logic                          jump,
  output logic [XLEN-1:0]               pc,
  output logic [XLEN-1:0]               instr_if,
  output logic [XLEN-1:0]               instr_id,
  output logic [XLEN-1:0]               pc_id,
  output logic                          valid_id,
  output logic                          fault,
  output logic [1:0]                    state
);

  localparam int unsigned AW = $clog2(IMEM_DEPTH);
  // Bits of pc_id+4 replaced by the jump field; only the top nibble survives.
  localparam logic [XLEN-1:0] JMP_LOW_MASK = XLEN'(32'h0FFF_FFFF);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_t;

  state_t          state_q;
  state_t          state_n;

  logic [XLEN-1:0] imem [IMEM_DEPTH];

  logic [XLEN-1:0] pc_word;
  logic [XLEN-1:0] pc_plus4;
  logic [XLEN-1:0] link;
  logic [XLEN-1:0] br_off;
  logic [XLEN-1:0] br_target;
  logic [XLEN-1:0] jmp_target;
  logic            in_range;
  logic            take_jump;
  logic            take_branch;

  logic [XLEN-1:0] pc_n;
  logic [XLEN-1:0] instr_id_n;
  logic [XLEN-1:0] pc_id_n;
  logic            valid_id_n;
  logic            fault_n;

  // Fetch address decode and redirect targets
  assign pc_word     = pc >> 2;
  assign in_range    = (pc_word < XLEN'(IMEM_DEPTH));
  assign pc_plus4    = pc + XLEN'(4);
  assign link        = pc_id + XLEN'(4);
  assign br_off      = {{(XLEN-16){instr_id[15]}}, instr_id[15:0]} << 2;
  assign br_target   = link + br_off;
  assign jmp_target  = (link & ~JMP_LOW_MASK) | XLEN'({instr_id[25:0], 2'b00});
  assign take_jump   = valid_id & jump;
  assign take_branch = valid_id & branch & ~jump;

  assign instr_if = (state_q == RUN && in_range) ? imem[pc_word[AW-1:0]] : '0;
  assign state    = state_q;

  // Instruction memory: loadable only while idle, survives reset
  always_ff @(posedge clk) begin
    if (imem_we && state_q == IDLE) begin
      imem[imem_waddr] <= imem_wdata;
    end
  end

  // Next-state and next-pipeline-register logic
  always_comb begin
    state_n    = state_q;
    pc_n       = pc;
    instr_id_n = instr_id;
    pc_id_n    = pc_id;
    valid_id_n = valid_id;
    fault_n    = fault;
    case (state_q)
      IDLE: begin
        if (run) begin
          state_n = RUN;
        end
      end
      RUN: begin
        if (!stall) begin
          if (!in_range) begin
            fault_n    = 1'b1;
            state_n    = HALT;
            valid_id_n = 1'b0;
          end else begin
            pc_id_n = pc;
            if (take_jump) begin
              pc_n = jmp_target;
            end else if (take_branch) begin
              pc_n = br_target;
            end else begin
              pc_n = pc_plus4;
            end
            // Redirect or flush squashes the wrong-path word just fetched
            if (take_jump || take_branch || flush) begin
              instr_id_n = '0;
              valid_id_n = 1'b0;
            end else begin
              instr_id_n = instr_if;
              valid_id_n = 1'b1;
            end
          end
        end
      end
      HALT: begin
        state_n = HALT;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  // State and pipeline registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      pc       <= XLEN'(RESET_PC);
      instr_id <= '0;
      pc_id    <= '0;
      valid_id <= 1'b0;
      fault    <= 1'b0;
    end else begin
      state_q  <= state_n;
      pc       <= pc_n;
      instr_id <= instr_id_n;
      pc_id    <= pc_id_n;
      valid_id <= valid_id_n;
      fault    <= fault_n;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: stimulus drives a behavioural model and
// queues expected post-edge outputs; a monitor pops and compares each cycle.
module tb_fetch_unit;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned DEPTH = 16;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        run = 1'b0;
  logic        imem_we = 1'b0;
  logic [3:0]  imem_waddr = '0;
  logic [31:0] imem_wdata = '0;
  logic        stall = 1'b0;
  logic        flush = 1'b0;
  logic        branch = 1'b0;
  logic        jump = 1'b0;
  logic [31:0] pc;
  logic [31:0] instr_if;
  logic [31:0] instr_id;
  logic [31:0] pc_id;
  logic        valid_id;
  logic        fault;
  logic [1:0]  state;

  fetch_unit #(.XLEN(XLEN), .IMEM_DEPTH(DEPTH), .RESET_PC(0)) dut (
    .clk(clk), .reset(reset), .run(run), .imem_we(imem_we),
    .imem_waddr(imem_waddr), .imem_wdata(imem_wdata), .stall(stall),
    .flush(flush), .branch(branch), .jump(jump), .pc(pc),
    .instr_if(instr_if), .instr_id(instr_id), .pc_id(pc_id),
    .valid_id(valid_id), .fault(fault), .state(state)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  st;
    logic [31:0] pc;
    logic [31:0] iif;
    logic [31:0] iid;
    logic [31:0] pcid;
    logic        v;
    logic        f;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model state (0 idle, 1 running, 2 halted)
  int          m_st;
  logic [31:0] m_pc, m_iid, m_pcid;
  logic        m_v, m_f;
  logic [31:0] m_mem [DEPTH];

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: actual=%h expected=%h", name, $time, act, exp);
    end
  endfunction

  function automatic void model_reset();
    m_st = 0; m_pc = 0; m_iid = 0; m_pcid = 0; m_v = 1'b0; m_f = 1'b0;
  endfunction

  function automatic exp_t snap();
    exp_t e;
    e.st   = 2'(m_st);
    e.pc   = m_pc;
    e.iif  = (m_st == 1 && (m_pc >> 2) < DEPTH) ? m_mem[m_pc >> 2] : 32'h0;
    e.iid  = m_iid;
    e.pcid = m_pcid;
    e.v    = m_v;
    e.f    = m_f;
    return e;
  endfunction

  // One clock of the fetch stage, written from the behavioural rules
  function automatic void model_step(logic r, logic we, logic [3:0] wa, logic [31:0] wd,
                                     logic s, logic fl, logic br, logic jp);
    logic [31:0] fetched, after_id, nxt;
    int          off;
    bit          redirect;
    if (m_st == 0) begin
      if (we) m_mem[wa] = wd;
      if (r) m_st = 1;
    end else if (m_st == 1 && !s) begin
      if ((m_pc >> 2) >= DEPTH) begin
        m_f = 1'b1; m_st = 2; m_v = 1'b0;
      end else begin
        fetched  = m_mem[m_pc >> 2];
        after_id = m_pcid + 32'd4;
        off      = $signed(m_iid[15:0]);
        redirect = m_v && (jp || br);
        if (m_v && jp)      nxt = {after_id[31:28], m_iid[25:0], 2'b00};
        else if (m_v && br) nxt = after_id + 32'(off * 4);
        else                nxt = m_pc + 32'd4;
        m_pcid = m_pc;
        if (redirect || fl) begin m_iid = 0; m_v = 1'b0; end
        else begin m_iid = fetched; m_v = 1'b1; end
        m_pc = nxt;
      end
    end
  endfunction

  // Monitor: compare DUT against the queued expectation after every edge
  always begin
    exp_t e;
    @(posedge clk);
    #1;
    if (q.size() > 0) begin
      e = q.pop_front();
      chk("state", 32'(state), 32'(e.st));
      chk("pc", pc, e.pc);
      chk("instr_if", instr_if, e.iif);
      chk("instr_id", instr_id, e.iid);
      chk("pc_id", pc_id, e.pcid);
      chk("valid_id", 32'(valid_id), 32'(e.v));
      chk("fault", 32'(fault), 32'(e.f));
    end
  end

  task automatic cyc(input logic r, input logic we, input logic [3:0] wa, input logic [31:0] wd,
                     input logic s, input logic fl, input logic br, input logic jp);
    @(negedge clk);
    run = r; imem_we = we; imem_waddr = wa; imem_wdata = wd;
    stall = s; flush = fl; branch = br; jump = jp;
    model_step(r, we, wa, wd, s, fl, br, jp);
    q.push_back(snap());
  endtask

  task automatic after_edge();
    @(posedge clk);
    #2;
  endtask

  // Assert reset between edges and confirm outputs clear without a clock
  task automatic do_reset();
    @(negedge clk);
    run = 0; imem_we = 0; stall = 0; flush = 0; branch = 0; jump = 0;
    #3 reset = 1'b0;
    #1;
    chk("rst_pc", pc, 32'h0);
    chk("rst_instr_id", instr_id, 32'h0);
    chk("rst_pc_id", pc_id, 32'h0);
    chk("rst_valid_id", 32'(valid_id), 32'h0);
    chk("rst_fault", 32'(fault), 32'h0);
    chk("rst_state", 32'(state), 32'h0);
    chk("rst_instr_if", instr_if, 32'h0);
    model_reset();
    q.delete();
    @(negedge clk);
    reset = 1'b1;
  endtask

  function automatic logic [31:0] rand_word();
    logic [31:0] w;
    w = $urandom;
    case ($urandom_range(0, 2))
      0: w = w & 32'hFC00_000F;
      1: w = (w & 32'hFC00_0000) | 32'h0000_FFF0 | (w & 32'hF);
      default: ;
    endcase
    return w;
  endfunction

  initial begin
    logic [31:0] img [DEPTH];
    model_reset();
    for (int i = 0; i < int'(DEPTH); i++) m_mem[i] = 32'h0;
    img[0] = 32'h1111_1111;
    img[1] = 32'h0800_0010;
    img[2] = 32'h1400_FFFE;
    img[3] = 32'h3333_3333;
    for (int i = 4; i < int'(DEPTH); i++) img[i] = 32'hAA00_0000 + 32'(i);

    // Load image while idle, then straight-line fetch
    do_reset();
    for (int i = 0; i < int'(DEPTH); i++) cyc(0, 1, 4'(i), img[i], 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0, 0, 0);
    after_edge();
    chk("seq_pc", pc, 32'd12);
    chk("seq_instr_id", instr_id, 32'h1400_FFFE);
    chk("seq_pc_id", pc_id, 32'd8);

    // Backward branch squashes the fetched word
    cyc(1, 0, 0, 0, 0, 0, 1, 0);
    after_edge();
    chk("br_pc", pc, 32'd4);
    chk("br_valid", 32'(valid_id), 32'h0);
    chk("br_instr_id", instr_id, 32'h0);

    // Jump beats branch, then out-of-range fetch halts
    cyc(1, 0, 0, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0, 1, 1);
    after_edge();
    chk("jmp_pc", pc, 32'h40);
    cyc(1, 0, 0, 0, 0, 0, 0, 0);
    after_edge();
    chk("halt_fault", 32'(fault), 32'h1);
    chk("halt_state", 32'(state), 32'h2);
    cyc(1, 1, 0, 32'hDEAD_0000, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 1, 1, 1);

    // Stall holds a pending branch; memory writes during run are dropped
    do_reset();
    cyc(1, 0, 0, 0, 0, 0, 0, 0);
    cyc(1, 1, 0, 32'hDEAD_BEEF, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) cyc(1, 0, 0, 0, 1, 1, 1, 0);
    after_edge();
    chk("stall_pc", pc, 32'd12);
    chk("stall_instr_id", instr_id, 32'h1400_FFFE);
    cyc(1, 0, 0, 0, 0, 0, 1, 0);
    after_edge();
    chk("unstall_br_pc", pc, 32'd4);
    cyc(1, 0, 0, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0, 0, 0);
    do_reset();
    cyc(1, 0, 0, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0, 0, 0);
    after_edge();
    chk("mem_kept", instr_id, 32'h1111_1111);

    // Randomised episodes
    for (int ep = 0; ep < 8; ep++) begin
      do_reset();
      for (int i = 0; i < 20; i++)
        cyc(0, 1'($urandom_range(0, 3) != 0), 4'($urandom), rand_word(), 0, 0, 0, 0);
      cyc(1, 0, 0, 0, 0, 0, 0, 0);
      for (int i = 0; i < 200; i++)
        cyc(1'($urandom_range(0, 7) != 0), 1'($urandom_range(0, 7) == 0), 4'($urandom),
            $urandom, 1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 7) == 0),
            1'($urandom_range(0, 5) == 0), 1'($urandom_range(0, 7) == 0));
    end

    repeat (2) @(negedge clk);
    chk("queue_drained", 32'(q.size()), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
